// File: rtl/pe_pkg.sv
// Shared state encoding, width helpers and overflow-aware accumulate for the vector MAC PE.
package pe_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DOT_W      = 2 * DEF_DATA_W + $clog2(DEF_LANES);

  // Operands are sign-extended to SAT_W so any ACC_W up to SAT_W-1 shares one helper.
  localparam int unsigned SAT_W = 64;
  localparam logic signed [SAT_W:0] SAT_ONE = 65'sd1;

  function automatic int unsigned dot_width(input int unsigned data_w, input int unsigned lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

  // Returns {ovf, result}; the caller keeps the low acc_w bits of result.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] acc,
                                             input logic signed [SAT_W-1:0] dot,
                                             input logic                    sat_en,
                                             input int unsigned             acc_w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    logic                  ovf;
    logic [SAT_W-1:0]      res;
    sum   = {acc[SAT_W-1], acc} + {dot[SAT_W-1], dot};
    max_v = (SAT_ONE <<< (acc_w - 1)) - SAT_ONE;
    min_v = ~max_v;
    ovf   = (sum > max_v) || (sum < min_v);
    res   = sum[SAT_W-1:0];
    if (ovf && sat_en) begin
      res = (sum > max_v) ? max_v[SAT_W-1:0] : min_v[SAT_W-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/pe_dot_lanes.sv
// Combinational LANES-way signed multiply and adder tree.
module pe_dot_lanes #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DOT_W  = 18
) (
  input  logic [LANES*DATA_W-1:0] act,
  input  logic [LANES*DATA_W-1:0] wgt,
  output logic signed [DOT_W-1:0] dot
);

  logic signed [DATA_W-1:0]   a;
  logic signed [DATA_W-1:0]   b;
  logic signed [2*DATA_W-1:0] p;

  always_comb begin
    a   = '0;
    b   = '0;
    p   = '0;
    dot = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      a   = act[i*DATA_W +: DATA_W];
      b   = wgt[i*DATA_W +: DATA_W];
      p   = (2 * DATA_W)'(a) * (2 * DATA_W)'(b);
      dot = dot + DOT_W'(p);
    end
  end

endmodule

// File: rtl/pe_vec_mac.sv
// Systolic PE: LANES-wide dot product into an output-stationary accumulator with psum drain.
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        k_len,
  input  logic                    sat_en,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] act,
  input  logic [LANES*DATA_W-1:0] wgt,
  output logic [LANES*DATA_W-1:0] act_out,
  output logic [LANES*DATA_W-1:0] wgt_out,
  output logic                    valid_out,
  output logic [ACC_W-1:0]        psum,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic                    busy,
  output logic                    ovf
);

  localparam int unsigned DW = dot_width(DATA_W, LANES);

  logic signed [DW-1:0]    dot;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        klen_q, klen_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [SAT_W:0]          sat_res;
  logic                    unused_sat_hi;

  pe_dot_lanes #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .DOT_W (DW)
  ) u_dot (
    .act(act),
    .wgt(wgt),
    .dot(dot)
  );

  assign sat_res       = sat_add(SAT_W'(acc_q), SAT_W'(dot), sat_en, ACC_W);
  assign unused_sat_hi = ^sat_res[SAT_W-1:ACC_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          klen_d  = k_len;
          state_d = (k_len == '0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sat_res[ACC_W-1:0];
          ovf_d = ovf_q | sat_res[SAT_W];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == klen_q - CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // start in this cycle is dropped; the next IDLE cycle accepts it.
        if (psum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      klen_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      act_out   <= '0;
      wgt_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      klen_q    <= klen_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      act_out   <= act;
      wgt_out   <= wgt;
      valid_out <= in_valid;
    end
  end

  assign psum       = acc_q;
  assign psum_valid = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign ovf        = ovf_q;

endmodule

// File: doc/pe_vec_mac.md
Name: pe_vec_mac

Overview:
- Next-generation systolic processing element for the tensor-core array: a LANES-wide dot product per cycle feeding one output-stationary accumulator.
- Forwards activation, weight and a valid flag to its east/south neighbours with 1-cycle latency.
- Adds tile-length control, saturating/wrapping accumulation and a ready/valid drain of the finished partial sum.
- Instantiated in the array fabric in place of the scalar PE.

Parameters:
- DATA_W, 8, signed width of each activation/weight element.
- ACC_W, 32, signed accumulator / psum width (must be >= 2*DATA_W+$clog2(LANES)).
- LANES, 4, elements multiplied per beat (>=1).
- CNT_W, 16, width of the tile-length counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin tile: clear accumulator, latch k_len; honoured only in IDLE.
- k_len  in  CNT_W  number of valid beats in the tile.
- sat_en  in  1  1 = saturate on overflow, 0 = two's-complement wrap; sampled every beat.
- in_valid  in  1  act/wgt beat valid.
- act  in  LANES*DATA_W  packed signed activations, lane 0 in LSBs.
- wgt  in  LANES*DATA_W  packed signed weights.
- act_out  out  LANES*DATA_W  registered act.
- wgt_out  out  LANES*DATA_W  registered wgt.
- valid_out  out  1  registered in_valid.
- psum  out  ACC_W  signed accumulator value.
- psum_valid  out  1  finished tile sum available.
- psum_ready  in  1  consumer accepts psum.
- busy  out  1  state != IDLE.
- ovf  out  1  sticky overflow flag for the current tile.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counter 0.
- Forwarding: act_out/wgt_out/valid_out <= act/wgt/in_valid every cycle in every state, independent of the FSM.
- FSM IDLE:
  - start=1 and k_len=0: acc<=0, ovf<=0, go to DRAIN.
  - start=1 and k_len>0: acc<=0, ovf<=0, cnt<=0, latch k_len, go to ACCUM.
- FSM ACCUM:
  - On each in_valid beat, acc <= acc + dot, and cnt increments.
  - When cnt reaches the latched k_len-1 and in_valid=1, the final add is registered and the FSM goes to DRAIN.
  - In-valid gaps stall the counter; the accumulator holds.
- FSM DRAIN:
  - psum_valid=1 and psum is held stable.
  - psum_ready=1 moves the FSM to IDLE, with psum_valid=0 the next cycle.
  - psum keeps its value until the next start.
- psum_valid rises the cycle after the last accepted beat (1-cycle MAC latency).
- start outside IDLE is ignored. in_valid outside ACCUM is forwarded only, never accumulated.
- start on the same cycle that DRAIN completes is ignored; it is accepted the following cycle.
- Arithmetic:
  - Lane products are signed 2*DATA_W bits.
  - dot = signed sum of the products, width 2*DATA_W+$clog2(LANES), sign-extended to ACC_W+1.
  - The sum is computed at ACC_W+1 bits and overflow is detected there.
  - sat_en=1: result clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat_en=0: result is the low ACC_W bits.
  - Either mode sets ovf on overflow; ovf is sticky until the next accepted start.
- psum = acc (registered), visible in all states.
- rst_n low mid-tile: immediate return to IDLE with all outputs 0, and no psum_valid is produced.

Decomposition:
- Package pe_pkg:
  - state enum {IDLE, ACCUM, DRAIN}
  - localparam DOT_W
  - function sat_add(acc, dot, sat_en) returning {ovf, result}
- Sub-module pe_dot_lanes: purely combinational LANES-way signed multiply and adder tree, producing dot.

Test Plan:
- LANES=4, k_len=3, all act=2, all wgt=3, in_valid held 3 cycles -> psum=72, psum_valid high the cycle after beat 3, ovf=0.
- Same stimulus with in_valid 1,0,1,0,1 -> psum=72, busy high throughout; valid_out/act_out mirror the inputs delayed by exactly 1 cycle.
- ACC_W=16, LANES=4, act=wgt=127, k_len=1:
  - sat_en=1 -> psum=32767, ovf=1.
  - sat_en=0 -> psum=-1020, ovf=1.
- start with k_len=0 -> psum=0, psum_valid=1 the next cycle; in_valid beats presented meanwhile are not accumulated.
- DRAIN with psum_ready=0 for 5 cycles plus a start pulse -> psum and psum_valid held, start ignored; psum_ready=1 -> IDLE next cycle, then a new start is accepted.
- rst_n asserted after 2 of 4 beats -> all outputs 0 asynchronously, IDLE; a fresh tile then gives the correct sum with no residue.
